// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the add_sched scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_sched_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Ceiling log2 usable in constant expressions (port and parameter widths)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: combinational.
// Backpressure: en=0 suppresses every grant; requesters simply stay pending.
// ADD_SCHED_PRIO0_EN: requester 0 wins outright whenever it is requesting.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    // Rotating search starting at ptr; first valid requester wins
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (en) begin
`ifdef ADD_SCHED_PRIO0_EN
            // Requester 0 bypasses the rotation entirely
            if (req[0]) begin
                gnt_any = 1'b1;
            end
`endif
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!gnt_any && req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(idx);
                end
            end
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/add_sched.sv
// Shares one fixed-latency pipelined adder among NREQ requesters, returning ID-tagged sums.
// Latency: grant is combinational; a sum returns LAT cycles after its operands are accepted.
// Backpressure: requesters wait on req_ready; no response backpressure; drain quiesces issue.
// Optional macro ADD_SCHED_PRIO0_EN gives requester 0 strict priority over the rotation.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int IDW   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_x,
    input  logic [NREQ*WIDTH-1:0]    req_y,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         add_x,
    output logic [WIDTH-1:0]         add_y,
    input  logic [WIDTH-1:0]         add_sum,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    input  logic                     drain,
    output logic                     drained,
    output logic [clog2(LAT+1)-1:0]  inflight
);

    localparam int INW = clog2(LAT + 1);

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic              issue_en;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;
    logic [LAT-1:0]    tag_vld;
    logic [IDW-1:0]    tag_id [LAT];
    logic              ret;

    // Issue only while running; a drain request wins over a same-cycle grant
    assign issue_en = (state == ST_RUN) && !drain && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (issue_en),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;
    assign ret       = tag_vld[LAT-1];
    assign rsp_valid = tag_vld[LAT-1];
    assign rsp_id    = tag_id[LAT-1];
    assign rsp_sum   = add_sum;
    assign drained   = (state == ST_HALT);

    // Operand mux toward the adder; zero when nothing is granted
    always_comb begin
        add_x = '0;
        add_y = '0;
        if (gnt_any) begin
            add_x = req_x[int'(gnt_id)*WIDTH +: WIDTH];
            add_y = req_y[int'(gnt_id)*WIDTH +: WIDTH];
        end
    end

    // Rotation pointer advances past the winner; priority wins leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
`ifdef ADD_SCHED_PRIO0_EN
            if (gnt_id != '0)
                rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
`else
            rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
`endif
        end
    end

    // Tag pipeline mirrors the adder so each sum emerges with its requester ID
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
        end else begin
            for (int k = LAT-1; k > 0; k--) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            tag_vld[0] <= gnt_any;
            tag_id[0]  <= gnt_id;
        end
    end

    // Outstanding-operation count; issue and return in one cycle cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({gnt_any, ret})
                2'b10:   inflight <= inflight + INW'(1);
                2'b01:   inflight <= inflight - INW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Drain sequencing: stop issuing, wait for the pipe to empty, park in HALT
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (drain) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain)              state_nxt = ST_RUN;
                else if (inflight == '0) state_nxt = ST_HALT;
            end
            ST_HALT:  if (!drain) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_add_sched.sv
module tb_add_sched;

    localparam int WIDTH = 15;
    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int IDW   = 2;
    localparam int INW   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_x;
    logic [NREQ*WIDTH-1:0]   req_y;
    logic [NREQ-1:0]         req_ready;
    logic [WIDTH-1:0]        add_x;
    logic [WIDTH-1:0]        add_y;
    logic [WIDTH-1:0]        add_sum;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [WIDTH-1:0]        rsp_sum;
    logic                    drain;
    logic                    drained;
    logic [INW-1:0]          inflight;

    add_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .LAT   (LAT),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .drain     (drain),
        .drained   (drained),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    // Attached adder: fixed LAT-edge pipeline, no stall
    logic [WIDTH-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= add_x + add_y;
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum = apipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int id;
        int sum;
        int due;
    } exp_t;

    exp_t q[$];
    int   hist[$];

    // Reference model: decides which requester should win, predicts results
    initial begin : model
        int m_mode;   // 0 run, 1 drain, 2 halt
        int m_ptr;
        int exp_inf;
        int gid;
        int xv, yv;
        logic allowed;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        m_mode = 0;
        m_ptr  = 0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                while (hist.size() > 0 && hist[0] < cyc - LAT) void'(hist.pop_front());
                exp_inf = 0;
                foreach (hist[j]) if (hist[j] >= cyc - LAT && hist[j] < cyc) exp_inf++;

                allowed = !rst && (m_mode == 0) && !drain;
                gid = -1;
                if (allowed) begin
`ifdef ADD_SCHED_PRIO0_EN
                    if (req_valid[0]) gid = 0;
`endif
                    for (int k = 0; k < NREQ; k++)
                        if (gid < 0 && req_valid[(m_ptr + k) % NREQ]) gid = (m_ptr + k) % NREQ;
                end
                exp_rdy = '0;
                if (gid >= 0) exp_rdy[gid] = 1'b1;

                chk("req_ready", int'(req_ready), int'(exp_rdy));
                chk("drained", int'(drained), (m_mode == 2) ? 1 : 0);
                chk("inflight", int'(inflight), exp_inf);

                if (gid >= 0) begin
                    xv = int'(req_x[gid*WIDTH +: WIDTH]);
                    yv = int'(req_y[gid*WIDTH +: WIDTH]);
                    chk("add_x", int'(add_x), xv);
                    chk("add_y", int'(add_y), yv);
                    e.id  = gid;
                    e.sum = (xv + yv) % (1 << WIDTH);
                    e.due = cyc + LAT;
                    q.push_back(e);
                    hist.push_back(cyc);
`ifdef ADD_SCHED_PRIO0_EN
                    if (gid != 0) m_ptr = (gid + 1) % NREQ;
`else
                    m_ptr = (gid + 1) % NREQ;
`endif
                end else begin
                    chk("add_x_idle", int'(add_x), 0);
                    chk("add_y_idle", int'(add_y), 0);
                end

                if (rst) begin
                    m_mode = 0;
                    m_ptr  = 0;
                    hist.delete();
                    for (int j = q.size() - 1; j >= 0; j--)
                        if (q[j].due > cyc) q.delete(j);
                end else begin
                    case (m_mode)
                        0: if (drain) m_mode = 1;
                        1: if (!drain) m_mode = 0;
                           else if (exp_inf == 0) m_mode = 2;
                        default: if (!drain) m_mode = 0;
                    endcase
                end
            end
        end
    end

    // Response monitor: every pulse must match the oldest outstanding prediction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("rsp_valid_unexpected", int'(rsp_valid), 0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_cycle", cyc, e.due);
                        chk("rsp_id", int'(rsp_id), e.id);
                        chk("rsp_sum", int'(rsp_sum), e.sum);
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    chk("rsp_valid_missing", int'(rsp_valid), 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y);
        req_x[i*WIDTH +: WIDTH] = WIDTH'(x);
        req_y[i*WIDTH +: WIDTH] = WIDTH'(y);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom), int'($urandom));
    endtask

    initial begin : stim
        logic seen;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        drain     = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (2) step();

        // Single request from requester 2
        set_op(2, 100, 23);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (5) step();

        // Fairness: all requesters hold valid
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (5) step();

        // Modular wrap of the sum
        set_op(1, 15'h7FFF, 15'h0002);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (5) step();

        // Drain with three operations in flight
        req_valid = 4'b1111;
        rand_ops();
        repeat (3) step();
        drain = 1'b1;
        seen  = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (drained) seen = 1'b1;
        end
        chk("drained_wait", int'(drained), 1);
        step();
        drain = 1'b0;
        repeat (4) step();
        req_valid = '0;
        repeat (5) step();

        // Reset with two operations in flight
        req_valid = 4'b1010;
        rand_ops();
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '0;
        repeat (6) step();

        // Randomized traffic with drain toggles and sporadic resets
        for (int n = 0; n < 800; n++) begin
            req_valid = NREQ'($urandom);
            rand_ops();
            if ($urandom_range(0, 15) == 0) drain = ~drain;
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst   = 1'b0;
        drain = 1'b0;

        // Requesters 0 and 1 continuously valid
        req_valid = 4'b0011;
        for (int n = 0; n < 8; n++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (8) step();

        chk("pending_at_end", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
